touch_button_debounce: RTL and testbench

//  Consumes the per-frame region-hit strobe from the touch-region detector (outtd) and turns it

---
 rtl/touch_button_debounce.sv | 144 ++++++++++++++
 tb/tb_touch_button_debounce.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/touch_button_debounce.sv
// Debounced on-screen button driven by the per-frame region-hit strobe.
// Produces a stable level, press/release/long-press pulses, a toggle and a press counter.
module touch_button_debounce #(
    parameter int unsigned DEB_SAMPLES  = 4,
    parameter int unsigned LONG_SAMPLES = 64,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic       touch_in,
    output logic       btn_state,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       toggle_state,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_SAMPLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] deb_cnt, deb_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic             long_done, long_done_nxt;
    logic             press_evt, release_evt, long_evt;

    logic             btn_nxt, press_nxt, release_nxt, long_nxt, toggle_nxt;
    logic [7:0]       count_nxt;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            btn_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            toggle_state  <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            hold_cnt      <= hold_nxt;
            long_done     <= long_done_nxt;
            btn_state     <= btn_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            toggle_state  <= toggle_nxt;
            press_count   <= count_nxt;
        end
    end

    // Next-state and counter update; everything holds on edges without a sample
    always_comb begin
        state_nxt     = state;
        deb_nxt       = deb_cnt;
        hold_nxt      = hold_cnt;
        long_done_nxt = long_done;
        press_evt     = 1'b0;
        release_evt   = 1'b0;
        long_evt      = 1'b0;
        if (sample_en) begin
            case (state)
                IDLE: begin
                    if (touch_in) begin
                        state_nxt = PRESS_CHK;
                        deb_nxt   = CNT_W'(1);
                    end
                end
                PRESS_CHK: begin
                    if (!touch_in) begin
                        state_nxt = IDLE;
                        deb_nxt   = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt     = PRESSED;
                        hold_nxt      = '0;
                        long_done_nxt = 1'b0;
                        press_evt     = 1'b1;
                    end else begin
                        deb_nxt = deb_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!touch_in) begin
                        state_nxt = REL_CHK;
                        deb_nxt   = CNT_W'(1);
                    end else if (!long_done && hold_cnt == LONG_LAST) begin
                        long_done_nxt = 1'b1;
                        long_evt      = 1'b1;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_nxt = hold_cnt + CNT_W'(1);
                    end
                end
                REL_CHK: begin
                    // A high sample here is a glitch: back to PRESSED with hold time untouched
                    if (touch_in) begin
                        state_nxt = PRESSED;
                        deb_nxt   = '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state_nxt   = IDLE;
                        hold_nxt    = '0;
                        release_evt = 1'b1;
                    end else begin
                        deb_nxt = deb_cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output next values from the accepted events
    always_comb begin
        btn_nxt     = btn_state;
        press_nxt   = press_evt;
        release_nxt = release_evt;
        long_nxt    = long_evt;
        toggle_nxt  = toggle_state;
        count_nxt   = press_count;
        if (press_evt) begin
            btn_nxt    = 1'b1;
            toggle_nxt = ~toggle_state;
            count_nxt  = press_count + 8'd1;
        end
        if (release_evt) begin
            btn_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_touch_button_debounce.sv
// Randomised and directed checks of touch_button_debounce against a run-length reference model.
module tb_touch_button_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic       touch_in;
    logic       btn_state, press_pulse, release_pulse, long_pulse, toggle_state;
    logic [7:0] press_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: pressed level, run of samples disagreeing with it, counted hold samples
    bit       m_pressed;
    int       m_run;
    int       m_held;
    bit       m_long_done;
    bit       m_tog;
    bit [7:0] m_cnt;
    bit       e_press, e_rel, e_long;
    int       n_press, n_rel, n_long;

    touch_button_debounce #(
        .DEB_SAMPLES (DEB),
        .LONG_SAMPLES(LONG),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_en    (sample_en),
        .touch_in     (touch_in),
        .btn_state    (btn_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .toggle_state (toggle_state),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pressed = 0; m_run = 0; m_held = 0; m_long_done = 0;
        m_tog = 0; m_cnt = 0; e_press = 0; e_rel = 0; e_long = 0;
    endtask

    task automatic model_sample(input bit t);
        e_press = 0; e_rel = 0; e_long = 0;
        if (!m_pressed) begin
            m_run = t ? m_run + 1 : 0;
            if (m_run == DEB) begin
                m_pressed = 1; m_run = 0; m_held = 0; m_long_done = 0;
                m_cnt = m_cnt + 8'd1; m_tog = !m_tog; e_press = 1;
            end
        end else if (!t) begin
            m_run++;
            if (m_run == DEB) begin
                m_pressed = 0; m_run = 0; e_rel = 1;
            end
        end else if (m_run > 0) begin
            m_run = 0;
        end else begin
            m_held++;
            if (m_held == LONG && !m_long_done) begin
                m_long_done = 1; e_long = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".btn"},    {7'd0, btn_state},     {7'd0, m_pressed});
        check({tag, ".press"},  {7'd0, press_pulse},   {7'd0, e_press});
        check({tag, ".rel"},    {7'd0, release_pulse}, {7'd0, e_rel});
        check({tag, ".long"},   {7'd0, long_pulse},    {7'd0, e_long});
        check({tag, ".toggle"}, {7'd0, toggle_state},  {7'd0, m_tog});
        check({tag, ".count"},  press_count,           m_cnt);
    endtask

    // One clock: drive on the falling edge, update the model on the rising edge, check 1 ns later
    task automatic step(input bit en, input bit t, input string tag);
        @(negedge clk);
        sample_en = en;
        touch_in  = t;
        @(posedge clk);
        if (en) model_sample(t);
        else begin e_press = 0; e_rel = 0; e_long = 0; end
        #1;
        check_all(tag);
        n_press += int'(press_pulse);
        n_rel   += int'(release_pulse);
        n_long  += int'(long_pulse);
    endtask

    // One valid sample in every four clocks; ignored clocks carry random touch_in
    task automatic sample(input bit t, input string tag);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), tag);
        step(1'b1, t, tag);
    endtask

    task automatic samples(input int n, input bit t, input string tag);
        for (int i = 0; i < n; i++) sample(t, tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit t;
        reset     = 1'b0;
        sample_en = 1'b0;
        touch_in  = 1'b0;
        n_press = 0; n_rel = 0; n_long = 0;
        model_clear();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // 2: basic press then release
        samples(3, 1'b1, "t2_pre");
        check({"t2_nopress"}, {7'd0, btn_state}, 8'd0);
        sample(1'b1, "t2_press");
        check("t2_press_pulse", {7'd0, press_pulse}, 8'd1);
        check("t2_count", press_count, 8'd1);
        check("t2_toggle", {7'd0, toggle_state}, 8'd1);
        samples(4, 1'b0, "t2_rel");
        check("t2_rel_pulse", {7'd0, release_pulse}, 8'd1);
        check("t2_btn_low", {7'd0, btn_state}, 8'd0);

        // 1: reset mid-press clears everything at once, then stays idle
        samples(4, 1'b1, "t1_press");
        async_reset("t1_reset");
        samples(3, 1'b0, "t1_idle");
        check("t1_count", press_count, 8'd0);

        // 3: interrupted debounce never accepts
        samples(3, 1'b1, "t3_a");
        sample(1'b0, "t3_b");
        samples(3, 1'b1, "t3_c");
        check("t3_btn", {7'd0, btn_state}, 8'd0);
        check("t3_count", press_count, 8'd0);
        samples(4, 1'b0, "t3_idle");

        // 4: long press fires once; release glitch absorbed, no second long pulse
        samples(4, 1'b1, "t4_press");
        n_long = 0; n_rel = 0;
        samples(12, 1'b1, "t4_hold");
        check("t4_long_once", 8'(n_long), 8'd1);
        samples(2, 1'b0, "t4_glitch");
        samples(21, 1'b1, "t4_hold2");
        check("t4_no_rel", 8'(n_rel), 8'd0);
        check("t4_long_still_once", 8'(n_long), 8'd1);
        check("t4_btn", {7'd0, btn_state}, 8'd1);
        samples(4, 1'b0, "t4_rel");

        // 6: sample_en low freezes everything; gaps mid-debounce still need exactly 4 samples
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, "t6_frozen");
        n_press = 0;
        step(1'b1, 1'b1, "t6_gap");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "t6_gap");
        step(1'b1, 1'b1, "t6_gap");
        step(1'b1, 1'b1, "t6_gap");
        for (int i = 0; i < 13; i++) step(1'b0, 1'b0, "t6_gap");
        check("t6_no_early", 8'(n_press), 8'd0);
        step(1'b1, 1'b1, "t6_gap4");
        check("t6_press", {7'd0, press_pulse}, 8'd1);
        samples(4, 1'b0, "t6_rel");

        // 5: 256 press/release cycles wrap the counter and restore the toggle
        async_reset("t5_reset");
        for (int k = 0; k < 256; k++) begin
            samples(4, 1'b1, "t5_press");
            samples(4, 1'b0, "t5_rel");
        end
        check("t5_wrap", press_count, 8'd0);
        check("t5_toggle", {7'd0, toggle_state}, 8'd0);

        // Random bursty touches with irregular sample strobes
        t = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 15) t = !t;
            if ($urandom_range(0, 2) == 0) step(1'b1, t, "rand");
            else step(1'b0, 1'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
